// File: rtl/quad_updown_decoder_pkg.sv
// Shared definitions for the quadrature decoder and any encoder models that
// drive it.
//   DIR_UP / DIR_DOWN : values reported on the updown output
//   phase_e           : the four {A,B} phase states of an incremental encoder
//   is_up_step        : true when prev->cur is one forward (A leads B) step
//   is_down_step      : true when prev->cur is one reverse (B leads A) step
package quad_updown_decoder_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_10 = 2'b10,
      PH_11 = 2'b11,
      PH_01 = 2'b01
   } phase_e;

   // Forward rotation walks 00 -> 10 -> 11 -> 01 -> 00.
   function automatic logic is_up_step(input logic [1:0] prev, input logic [1:0] cur);
      logic hit;
      hit = 1'b0;
      case ({prev, cur})
         {PH_00, PH_10},
         {PH_10, PH_11},
         {PH_11, PH_01},
         {PH_01, PH_00}: hit = 1'b1;
         default:        hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Reverse rotation walks 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic is_down_step(input logic [1:0] prev, input logic [1:0] cur);
      logic hit;
      hit = 1'b0;
      case ({prev, cur})
         {PH_00, PH_01},
         {PH_01, PH_11},
         {PH_11, PH_10},
         {PH_10, PH_00}: hit = 1'b1;
         default:        hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/quad_updown_decoder_sync_2ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
//   clk   : sampling clock
//   reset : asynchronous active-low reset, clears every stage to 0
//   d     : raw asynchronous input
//   q     : synchronized output, STAGES clocks behind d
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw input into the bottom of the chain.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Chain registers; reset to 0 so the decoder sees a known phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature A/B decoder in x4 mode with integrated position counter.
//   clk     : single rising-edge clock
//   reset   : asynchronous active-low reset
//   enable  : 1 = count valid transitions, 0 = hold count (A/B still tracked)
//   clear   : synchronous count clear, beats a simultaneous step
//   a_in    : raw phase A (asynchronous)
//   b_in    : raw phase B (asynchronous)
//   err_clr : synchronous clear of the sticky error flag
//   count   : WIDTH-bit position, wraps modulo 2**WIDTH
//   updown  : direction of the last counted step (1 = up)
//   step    : one-cycle pulse per counted transition
//   err     : sticky flag, set when A and B change in the same sample
module quad_updown_decoder
   import quad_updown_decoder_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             updown,
   output logic             step,
   output logic             err
);

   // The sync chains and prev need SYNC_STAGES+1 clocks to hold real samples.
   localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

   logic             a_s;
   logic             b_s;
   logic [1:0]       cur;
   logic             primed;
   logic             move_up;
   logic             move_down;
   logic             illegal;

   logic [1:0]       prev_q,   prev_d;
   logic [2:0]       prime_q,  prime_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic             updown_q, updown_d;
   logic             step_q,   step_d;
   logic             err_q,    err_d;

   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk   (clk),
      .reset (reset),
      .d     (a_in),
      .q     (a_s)
   );

   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk   (clk),
      .reset (reset),
      .d     (b_in),
      .q     (b_s)
   );

   // Decode the current phase against the previous sample and work out the
   // next counter, direction, step and error state.
   always_comb begin
      cur       = {a_s, b_s};
      primed    = (prime_q == PRIME_CYCLES);
      move_up   = is_up_step(prev_q, cur);
      move_down = is_down_step(prev_q, cur);
      illegal   = ((prev_q ^ cur) == 2'b11);

      prime_d  = primed ? prime_q : prime_q + 3'd1;
      prev_d   = cur;
      count_d  = count_q;
      updown_d = updown_q;
      step_d   = 1'b0;
      err_d    = err_clr ? 1'b0 : err_q;

      if (primed) begin
         // An illegal jump overrides err_clr and ignores enable.
         if (illegal) begin
            err_d = 1'b1;
         end else if (enable && (move_up || move_down)) begin
            step_d   = 1'b1;
            updown_d = move_up ? DIR_UP : DIR_DOWN;
            count_d  = move_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end
      end

      // clear wins over the count change but leaves step/updown alone.
      if (clear) begin
         count_d = '0;
      end
   end

   // State registers; reset also restarts the priming window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q   <= PH_00;
         prime_q  <= '0;
         count_q  <= '0;
         updown_q <= DIR_UP;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         prime_q  <= prime_d;
         count_q  <= count_d;
         updown_q <= updown_d;
         step_q   <= step_d;
         err_q    <= err_d;
      end
   end

   assign count  = count_q;
   assign updown = updown_q;
   assign step   = step_q;
   assign err    = err_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Self-checking bench for quad_updown_decoder (WIDTH=4, SYNC_STAGES=2).
// A table of phase edges with hand-computed results drives the main
// sequence; short hand-written sequences cover err_clr, clear, mid-run reset,
// priming with inputs held high and enable=0 tracking.
`timescale 1ns/1ps
module tb_quad_updown_decoder;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       clear;
   logic       a_in;
   logic       b_in;
   logic       err_clr;
   logic [3:0] count;
   logic       updown;
   logic       step;
   logic       err;

   int checks;
   int errors;

   typedef struct {
      logic       a;
      logic       b;
      logic       en;
      logic       exp_step;
      logic [3:0] exp_count;
      logic       exp_updown;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   quad_updown_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .clear   (clear),
      .a_in    (a_in),
      .b_in    (b_in),
      .err_clr (err_clr),
      .count   (count),
      .updown  (updown),
      .step    (step),
      .err     (err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic a, input logic b, input logic en,
                               input logic s, input logic [3:0] c,
                               input logic ud, input logic e);
      vec_t v;
      v.a = a; v.b = b; v.en = en;
      v.exp_step = s; v.exp_count = c; v.exp_updown = ud; v.exp_err = e;
      return v;
   endfunction

   // Next phase of a forward-rotating encoder.
   function automatic logic [1:0] nextUp(input logic [1:0] ph);
      logic [1:0] n;
      case (ph)
         2'b00:   n = 2'b10;
         2'b10:   n = 2'b11;
         2'b11:   n = 2'b01;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Drive one phase edge and watch the 4-cycle window: step must appear
   // exactly on the third clock after the edge and nowhere else.
   task automatic applyStimulus(input logic a, input logic b, input logic en,
                                input logic exp_step, input logic [3:0] exp_count,
                                input logic exp_updown, input logic exp_err,
                                input string name);
      a_in   = a;
      b_in   = b;
      enable = en;
      tick();
      checkOutput({name, " step c1"}, 32'(step), 32'd0);
      tick();
      checkOutput({name, " step c2"}, 32'(step), 32'd0);
      tick();
      checkOutput({name, " step c3"}, 32'(step), 32'(exp_step));
      checkOutput({name, " count"}, 32'(count), 32'(exp_count));
      checkOutput({name, " updown"}, 32'(updown), 32'(exp_updown));
      checkOutput({name, " err"}, 32'(err), 32'(exp_err));
      tick();
      checkOutput({name, " step c4"}, 32'(step), 32'd0);
   endtask

   initial begin
      logic [1:0] ph;
      checks  = 0;
      errors  = 0;
      reset   = 1'b0;
      enable  = 1'b1;
      clear   = 1'b0;
      a_in    = 1'b0;
      b_in    = 1'b0;
      err_clr = 1'b0;

      // x4 up sweep, full down sweep through the wrap, enable=0 tracking,
      // up through the 15->0 wrap, then an illegal 11->00 jump.
      vecs.push_back(mk(1,0,1, 1, 4'd1,  1, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd2,  1, 0));
      vecs.push_back(mk(0,1,1, 1, 4'd3,  1, 0));
      vecs.push_back(mk(0,0,1, 1, 4'd4,  1, 0));
      vecs.push_back(mk(1,0,1, 1, 4'd5,  1, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd6,  1, 0));
      vecs.push_back(mk(0,1,1, 1, 4'd7,  1, 0));
      vecs.push_back(mk(0,0,1, 1, 4'd8,  1, 0));
      vecs.push_back(mk(0,1,1, 1, 4'd7,  0, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd6,  0, 0));
      vecs.push_back(mk(1,0,1, 1, 4'd5,  0, 0));
      vecs.push_back(mk(0,0,1, 1, 4'd4,  0, 0));
      vecs.push_back(mk(0,1,1, 1, 4'd3,  0, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd2,  0, 0));
      vecs.push_back(mk(1,0,1, 1, 4'd1,  0, 0));
      vecs.push_back(mk(0,0,1, 1, 4'd0,  0, 0));
      vecs.push_back(mk(0,1,1, 1, 4'd15, 0, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd14, 0, 0));
      vecs.push_back(mk(0,1,0, 0, 4'd14, 0, 0));
      vecs.push_back(mk(0,0,0, 0, 4'd14, 0, 0));
      vecs.push_back(mk(1,0,1, 1, 4'd15, 1, 0));
      vecs.push_back(mk(1,1,1, 1, 4'd0,  1, 0));
      vecs.push_back(mk(0,0,1, 0, 4'd0,  1, 1));

      // Reset state.
      #12;
      checkOutput("reset count", 32'(count), 32'd0);
      checkOutput("reset updown", 32'(updown), 32'd1);
      checkOutput("reset step", 32'(step), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);

      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (4) tick();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].exp_step,
                       vecs[i].exp_count, vecs[i].exp_updown, vecs[i].exp_err,
                       $sformatf("vec%0d", i));
      end

      // err_clr clears the sticky flag.
      err_clr = 1'b1;
      tick();
      checkOutput("err_clr", 32'(err), 32'd0);

      // Illegal 00->11 while err_clr is held: the illegal jump wins.
      a_in = 1'b1;
      b_in = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("illegal beats err_clr", 32'(err), 32'd1);
      checkOutput("illegal no step", 32'(step), 32'd0);
      tick();
      checkOutput("err_clr after illegal", 32'(err), 32'd0);
      err_clr = 1'b0;

      // Up to count 5, then clear on the same cycle as the next up step.
      ph = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         ph = nextUp(ph);
         applyStimulus(ph[1], ph[0], 1'b1, 1'b1, 4'(i), 1'b1, 1'b0,
                       $sformatf("pre-clear up%0d", i));
      end
      ph = nextUp(ph);
      a_in = ph[1];
      b_in = ph[0];
      tick();
      tick();
      clear = 1'b1;
      tick();
      checkOutput("clear+step count", 32'(count), 32'd0);
      checkOutput("clear+step step", 32'(step), 32'd1);
      checkOutput("clear+step updown", 32'(updown), 32'd1);
      clear = 1'b0;
      tick();
      checkOutput("after clear count", 32'(count), 32'd0);

      // Count to 6, set err, then reset asynchronously mid-cycle.
      for (int i = 1; i <= 6; i++) begin
         ph = nextUp(ph);
         applyStimulus(ph[1], ph[0], 1'b1, 1'b1, 4'(i), 1'b1, 1'b0,
                       $sformatf("pre-reset up%0d", i));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1, "pre-reset illegal");
      a_in = 1'b1;
      b_in = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset count", 32'(count), 32'd0);
      checkOutput("async reset err", 32'(err), 32'd0);
      checkOutput("async reset updown", 32'(updown), 32'd1);
      tick();
      tick();
      reset = 1'b1;

      // AB held at 11 through release: priming must hide the apparent jump.
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput($sformatf("prime step c%0d", i), 32'(step), 32'd0);
         checkOutput($sformatf("prime err c%0d", i), 32'(err), 32'd0);
         checkOutput($sformatf("prime count c%0d", i), 32'(count), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "post-prime up");

      // enable=0 over four edges: count and updown held, no steps.
      ph = 2'b01;
      for (int i = 0; i < 4; i++) begin
         ph = nextUp(ph);
         applyStimulus(ph[1], ph[0], 1'b0, 1'b0, 4'd1, 1'b1, 1'b0,
                       $sformatf("disabled edge%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
